// File: rtl/vx_barrier_ctrl_if.sv
// Barrier request bundle between the warp-control decoder (master) and the
// barrier arbiter (slave). Carries at most one request per cycle; the
// wid/id/size fields are don't-care while bar_req_valid is low.
interface vx_barrier_ctrl_if #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4
);
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NB_WIDTH = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

  logic                bar_req_valid;
  logic [NW_WIDTH-1:0] bar_req_wid;
  logic [NB_WIDTH-1:0] bar_req_id;
  logic [NW_WIDTH-1:0] bar_req_size_m1;

  modport master (
    output bar_req_valid,
    output bar_req_wid,
    output bar_req_id,
    output bar_req_size_m1
  );

  modport slave (
    input bar_req_valid,
    input bar_req_wid,
    input bar_req_id,
    input bar_req_size_m1
  );
endinterface

// File: rtl/vx_barrier_ctrl.sv
// Barrier arbiter for the warp scheduler.
// Tracks per-barrier arrival counts and waiting-warp masks, parks arriving
// warps through bar_stall_mask and releases the whole group (one-cycle
// release pulse) when the last expected warp arrives. Malformed requests are
// dropped and flagged in the sticky err_valid.
// Optional watchdog: define VX_BAR_TIMEOUT_EN to add per-barrier wait
// counters that raise the sticky timeout_valid/timeout_id after
// TIMEOUT_CYCLES cycles in WAITING. Without the macro both are tied to 0.
module vx_barrier_ctrl #(
  parameter int NUM_WARPS      = 4,
  parameter int NUM_BARRIERS   = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NB_WIDTH = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  vx_barrier_ctrl_if.slave                 req_if,
  output logic [NUM_WARPS-1:0]             bar_stall_mask,
  output logic [NUM_BARRIERS*NW_WIDTH-1:0] barrier_ctrs,
  output logic                             release_valid,
  output logic [NB_WIDTH-1:0]              release_id,
  output logic [NUM_WARPS-1:0]             release_mask,
  output logic                             err_valid,
  output logic                             timeout_valid,
  output logic [NB_WIDTH-1:0]              timeout_id
);

  localparam logic [NW_WIDTH-1:0] CNT_ONE = NW_WIDTH'(1);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_chk
    $error("vx_barrier_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  // Per-barrier state: arrivals so far, parked warps, size latched on first arrival.
  logic [NW_WIDTH-1:0]  cnt_q  [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]  cnt_d  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] mask_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] mask_d [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]  size_q [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]  size_d [NUM_BARRIERS];

  // Registered outputs.
  logic [NUM_WARPS-1:0] stall_q, stall_d;
  logic                 rel_valid_q, rel_valid_d;
  logic [NB_WIDTH-1:0]  rel_id_q, rel_id_d;
  logic [NUM_WARPS-1:0] rel_mask_q, rel_mask_d;
  logic                 err_q, err_d;

  // Request decode.
  logic [NUM_WARPS-1:0] req_onehot;
  logic                 req_busy;
  logic                 req_dup;
  logic                 req_size_bad;
  logic                 req_err;
  logic                 req_last;

  // Classify the incoming request against the current barrier state.
  always_comb begin
    req_onehot                     = '0;
    req_onehot[req_if.bar_req_wid] = 1'b1;
    req_busy     = |(stall_q & req_onehot);
    req_dup      = |(mask_q[req_if.bar_req_id] & req_onehot);
    req_size_bad = (cnt_q[req_if.bar_req_id] != '0) &&
                   (req_if.bar_req_size_m1 != size_q[req_if.bar_req_id]);
    req_err      = req_busy | req_dup | req_size_bad;
    req_last     = (cnt_q[req_if.bar_req_id] == req_if.bar_req_size_m1);
  end

  // Next-state for counters, masks, release pulse, error flag and stall mask.
  always_comb begin
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    size_d      = size_q;
    rel_valid_d = 1'b0;
    rel_id_d    = '0;
    rel_mask_d  = '0;
    err_d       = err_q;
    stall_d     = '0;

    if (req_if.bar_req_valid) begin
      if (req_err) begin
        // Malformed request: leave every barrier untouched.
        err_d = 1'b1;
      end else if (req_last) begin
        // Last arrival (also a size-1 barrier): release the whole group now.
        cnt_d[req_if.bar_req_id]  = '0;
        mask_d[req_if.bar_req_id] = '0;
        rel_valid_d = 1'b1;
        rel_id_d    = req_if.bar_req_id;
        rel_mask_d  = mask_q[req_if.bar_req_id] | req_onehot;
      end else begin
        cnt_d[req_if.bar_req_id]  = cnt_q[req_if.bar_req_id] + CNT_ONE;
        mask_d[req_if.bar_req_id] = mask_q[req_if.bar_req_id] | req_onehot;
        if (cnt_q[req_if.bar_req_id] == '0) begin
          size_d[req_if.bar_req_id] = req_if.bar_req_size_m1;
        end else begin
          size_d[req_if.bar_req_id] = size_q[req_if.bar_req_id];
        end
      end
    end else begin
      err_d = err_q;
    end

    for (int b = 0; b < NUM_BARRIERS; b++) begin
      stall_d = stall_d | mask_d[b];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        cnt_q[b]  <= '0;
        mask_q[b] <= '0;
        size_q[b] <= '0;
      end
      stall_q     <= '0;
      rel_valid_q <= 1'b0;
      rel_id_q    <= '0;
      rel_mask_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      size_q      <= size_d;
      stall_q     <= stall_d;
      rel_valid_q <= rel_valid_d;
      rel_id_q    <= rel_id_d;
      rel_mask_q  <= rel_mask_d;
      err_q       <= err_d;
    end
  end

  // Flatten the per-barrier counters onto the status bus.
  always_comb begin
    barrier_ctrs = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      barrier_ctrs[b*NW_WIDTH +: NW_WIDTH] = cnt_q[b];
    end
  end

  assign bar_stall_mask = stall_q;
  assign release_valid  = rel_valid_q;
  assign release_id     = rel_id_q;
  assign release_mask   = rel_mask_q;
  assign err_valid      = err_q;

`ifdef VX_BAR_TIMEOUT_EN
  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WD_WIDTH-1:0] WD_ONE   = WD_WIDTH'(1);

  logic [WD_WIDTH-1:0] wd_q [NUM_BARRIERS];
  logic [WD_WIDTH-1:0] wd_d [NUM_BARRIERS];
  logic                to_valid_q, to_valid_d;
  logic [NB_WIDTH-1:0] to_id_q, to_id_d;
  logic                to_hit;

  // Watchdog: count cycles spent WAITING (saturating) and latch the first timeout.
  always_comb begin
    to_valid_d = to_valid_q;
    to_id_d    = to_id_q;
    to_hit     = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      if (cnt_d[b] == '0) begin
        wd_d[b] = '0;
      end else if (wd_q[b] == WD_LIMIT) begin
        wd_d[b] = wd_q[b];
      end else begin
        wd_d[b] = wd_q[b] + WD_ONE;
      end
      // Scan upward so the lowest-numbered barrier wins a simultaneous timeout.
      if (!to_valid_q && !to_hit && (wd_d[b] == WD_LIMIT)) begin
        to_hit  = 1'b1;
        to_id_d = NB_WIDTH'(b);
      end else begin
        to_hit = to_hit;
      end
    end
    if (to_hit) begin
      to_valid_d = 1'b1;
    end else begin
      to_valid_d = to_valid_q;
    end
  end

  // Watchdog registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        wd_q[b] <= '0;
      end
      to_valid_q <= 1'b0;
      to_id_q    <= '0;
    end else begin
      wd_q       <= wd_d;
      to_valid_q <= to_valid_d;
      to_id_q    <= to_id_d;
    end
  end

  assign timeout_valid = to_valid_q;
  assign timeout_id    = to_id_q;
`else
  assign timeout_valid = 1'b0;
  assign timeout_id    = '0;
`endif

endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// Self-checking bench for vx_barrier_ctrl. A queue-based model of the
// barriers (list of waiting warps per slot) predicts every output; one
// process compares each cycle, and directed steps pin key literals.
module tb_vx_barrier_ctrl;
  localparam int NW = 4;
  localparam int NB = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vx_barrier_ctrl_if #(.NUM_WARPS(NW), .NUM_BARRIERS(NB)) req_if ();

  logic [NW-1:0]   bar_stall_mask;
  logic [NB*2-1:0] barrier_ctrs;
  logic            release_valid;
  logic [1:0]      release_id;
  logic [NW-1:0]   release_mask;
  logic            err_valid;
  logic            timeout_valid;
  logic [1:0]      timeout_id;

  vx_barrier_ctrl #(.NUM_WARPS(NW), .NUM_BARRIERS(NB), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_if         (req_if),
    .bar_stall_mask (bar_stall_mask),
    .barrier_ctrs   (barrier_ctrs),
    .release_valid  (release_valid),
    .release_id     (release_id),
    .release_mask   (release_mask),
    .err_valid      (err_valid),
    .timeout_valid  (timeout_valid),
    .timeout_id     (timeout_id)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: waiting warps per barrier, latched size, wait age.
  int wq [NB][$];
  int lat_size [NB];
  int age [NB];
  logic [NW-1:0]   exp_stall;
  logic [NB*2-1:0] exp_ctrs;
  logic            exp_rel_valid;
  int              exp_rel_id;
  logic [NW-1:0]   exp_rel_mask;
  logic            exp_err;
  logic            exp_to_valid;
  int              exp_to_id;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      wq[b].delete();
      lat_size[b] = 0;
      age[b] = 0;
    end
    exp_stall = '0; exp_ctrs = '0; exp_rel_valid = 1'b0; exp_rel_id = 0;
    exp_rel_mask = '0; exp_err = 1'b0; exp_to_valid = 1'b0; exp_to_id = 0;
  endtask

  // Predict the outputs after the coming clock edge for this request.
  task automatic model_step(input bit v, input int w, input int b, input int s);
    logic [NW-1:0] parked;
    logic [NW-1:0] grp;
    bit in_b;
    parked = '0;
    for (int k = 0; k < NB; k++)
      for (int i = 0; i < wq[k].size(); i++) parked[wq[k][i]] = 1'b1;
    exp_rel_valid = 1'b0; exp_rel_id = 0; exp_rel_mask = '0;
    if (v) begin
      in_b = 1'b0;
      for (int i = 0; i < wq[b].size(); i++) if (wq[b][i] == w) in_b = 1'b1;
      if (parked[w] || in_b || (wq[b].size() > 0 && s != lat_size[b])) begin
        exp_err = 1'b1;
      end else if (wq[b].size() == s) begin
        grp = '0;
        for (int i = 0; i < wq[b].size(); i++) grp[wq[b][i]] = 1'b1;
        grp[w] = 1'b1;
        exp_rel_valid = 1'b1; exp_rel_id = b; exp_rel_mask = grp;
        wq[b].delete();
      end else begin
        if (wq[b].size() == 0) lat_size[b] = s;
        wq[b].push_back(w);
      end
    end
    exp_stall = '0;
    for (int k = 0; k < NB; k++) begin
      for (int i = 0; i < wq[k].size(); i++) exp_stall[wq[k][i]] = 1'b1;
      exp_ctrs[k*2 +: 2] = 2'(wq[k].size());
    end
`ifdef VX_BAR_TIMEOUT_EN
    for (int k = 0; k < NB; k++) begin
      if (wq[k].size() == 0) age[k] = 0;
      else if (age[k] < TO) age[k] = age[k] + 1;
    end
    if (!exp_to_valid) begin
      for (int k = NB - 1; k >= 0; k--) begin
        if (age[k] == TO) begin exp_to_valid = 1'b1; exp_to_id = k; end
      end
    end
`endif
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      cmp("stall_mask", 32'(bar_stall_mask), 32'(exp_stall));
      cmp("barrier_ctrs", 32'(barrier_ctrs), 32'(exp_ctrs));
      cmp("release_valid", 32'(release_valid), 32'(exp_rel_valid));
      if (exp_rel_valid) begin
        cmp("release_id", 32'(release_id), 32'(exp_rel_id));
        cmp("release_mask", 32'(release_mask), 32'(exp_rel_mask));
      end
      cmp("err_valid", 32'(err_valid), 32'(exp_err));
      cmp("timeout_valid", 32'(timeout_valid), 32'(exp_to_valid));
      if (exp_to_valid) cmp("timeout_id", 32'(timeout_id), 32'(exp_to_id));
    end
  end

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      req_if.bar_req_valid = 1'b0;
      model_reset();
      chk_en = 1'b1;
    end
  endtask

  task automatic cyc(input bit v, input int w, input int b, input int s);
    @(negedge clk);
    reset = 1'b0;
    req_if.bar_req_valid   = v;
    req_if.bar_req_wid     = 2'(w);
    req_if.bar_req_id      = 2'(b);
    req_if.bar_req_size_m1 = 2'(s);
    model_step(v, w, b, s);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    req_if.bar_req_valid = 1'b0;
    req_if.bar_req_wid = '0; req_if.bar_req_id = '0; req_if.bar_req_size_m1 = '0;
    model_reset();
    do_reset(2);
    settle();
    cmp("lit_reset_stall", 32'(bar_stall_mask), 32'h0);
    cmp("lit_reset_ctrs", 32'(barrier_ctrs), 32'h0);

    // 4-warp barrier 0
    cyc(1, 0, 0, 3); settle(); cmp("lit_b0_stall1", 32'(bar_stall_mask), 32'b0001);
    cmp("lit_b0_ctr1", 32'(barrier_ctrs[1:0]), 32'd1);
    cyc(1, 1, 0, 3); settle(); cmp("lit_b0_stall2", 32'(bar_stall_mask), 32'b0011);
    cyc(1, 2, 0, 3); settle(); cmp("lit_b0_stall3", 32'(bar_stall_mask), 32'b0111);
    cmp("lit_b0_ctr3", 32'(barrier_ctrs[1:0]), 32'd3);
    cyc(1, 3, 0, 3); settle();
    cmp("lit_b0_rel", 32'(release_valid), 32'd1);
    cmp("lit_b0_rel_mask", 32'(release_mask), 32'b1111);
    cmp("lit_b0_unstall", 32'(bar_stall_mask), 32'b0000);
    cmp("lit_b0_ctr0", 32'(barrier_ctrs[1:0]), 32'd0);
    cyc(0, 0, 0, 0); settle(); cmp("lit_rel_pulse", 32'(release_valid), 32'd0);

    // single-warp barrier 1
    cyc(1, 2, 1, 0); settle();
    cmp("lit_b1_rel_mask", 32'(release_mask), 32'b0100);
    cmp("lit_b1_rel_id", 32'(release_id), 32'd1);
    cmp("lit_b1_nostall", 32'(bar_stall_mask), 32'b0000);

    // interleaved barriers 0 and 2
    cyc(1, 0, 0, 1); cyc(1, 2, 2, 1); cyc(1, 1, 0, 1); settle();
    cmp("lit_il_rel0", 32'(release_mask), 32'b0011);
    cmp("lit_il_stall", 32'(bar_stall_mask), 32'b0100);
    cyc(1, 3, 2, 1); settle();
    cmp("lit_il_rel2_id", 32'(release_id), 32'd2);
    cmp("lit_il_rel2", 32'(release_mask), 32'b1100);
    cyc(0, 0, 0, 0);

    // protocol errors
    cyc(1, 1, 0, 1); settle(); cmp("lit_err_clear", 32'(err_valid), 32'd0);
    cyc(1, 1, 3, 0); settle();
    cmp("lit_err_busy", 32'(err_valid), 32'd1);
    cmp("lit_err_ctr3", 32'(barrier_ctrs[7:6]), 32'd0);
    cmp("lit_err_norel", 32'(release_valid), 32'd0);
    cyc(1, 2, 0, 2); settle(); cmp("lit_err_size_ctr", 32'(barrier_ctrs[1:0]), 32'd1);
    cyc(1, 0, 0, 1); settle(); cmp("lit_err_rel", 32'(release_mask), 32'b0011);

    // reset in the middle of a barrier
    cyc(1, 0, 0, 3); cyc(1, 1, 0, 3); settle();
    cmp("lit_mid_ctr2", 32'(barrier_ctrs[1:0]), 32'd2);
    do_reset(1); settle();
    cmp("lit_mid_ctrs", 32'(barrier_ctrs), 32'h0);
    cmp("lit_mid_stall", 32'(bar_stall_mask), 32'h0);
    cmp("lit_mid_norel", 32'(release_valid), 32'd0);
    cmp("lit_mid_err", 32'(err_valid), 32'd0);
    cyc(1, 2, 1, 1); cyc(1, 3, 1, 1); settle();
    cmp("lit_post_rel", 32'(release_mask), 32'b1100);

    // lone waiter on barrier 2
    cyc(1, 0, 2, 1);
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0);
    settle(); cmp("lit_to_early", 32'(timeout_valid), 32'd0);
    cyc(0, 0, 0, 0); settle();
`ifdef VX_BAR_TIMEOUT_EN
    cmp("lit_to_valid", 32'(timeout_valid), 32'd1);
    cmp("lit_to_id", 32'(timeout_id), 32'd2);
`else
    cmp("lit_to_off", 32'(timeout_valid), 32'd0);
`endif
    cmp("lit_to_stall", 32'(bar_stall_mask), 32'b0001);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vx_barrier_ctrl.md
Name: VX_barrier_ctrl

Overview:
- Barrier arbiter inside the warp scheduler.
- Consumes barrier requests decoded from the warp-control interface (warp_ctl barrier.valid/id/size).
- Holds per-barrier arrival counters and waiting-warp masks, and drives the barrier stall mask that the scheduler ORs into stalled_warps.
- Releases every waiting warp when the last expected warp arrives.

Parameters:
- NUM_WARPS, 4, number of hardware warps; NW_WIDTH = max(1, clog2(NUM_WARPS)).
- NUM_BARRIERS, 4, number of barrier slots; NB_WIDTH = max(1, clog2(NUM_BARRIERS)).
- TIMEOUT_CYCLES, 4096, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- bar_req_valid  in  1  barrier request this cycle (one per cycle max)
- bar_req_wid  in  NW_WIDTH  requesting warp
- bar_req_id  in  NB_WIDTH  barrier slot
- bar_req_size_m1  in  NW_WIDTH  expected participants minus 1
- bar_stall_mask  out  NUM_WARPS  warps currently parked on any barrier
- barrier_ctrs  out  NUM_BARRIERS*NW_WIDTH  arrival count per barrier (0 = idle)
- release_valid  out  1  one-cycle pulse on barrier release
- release_id  out  NB_WIDTH  released barrier
- release_mask  out  NUM_WARPS  warps unstalled by this release
- err_valid  out  1  sticky protocol-error flag
- timeout_valid  out  1  sticky watchdog flag (optional feature)
- timeout_id  out  NB_WIDTH  first barrier that timed out (optional feature)

Behaviour:
- Reset values: all counters 0, all masks 0, bar_stall_mask 0, release_* 0, err_valid 0, timeout_valid 0, timeout_id 0. Reset mid-operation drops all waiting state; no release pulse is generated.
- Per-barrier state:
  - IDLE (cnt == 0, mask 0).
  - WAITING (cnt > 0, stored size_m1 latched on the first arrival).
- Accepted request, with b = bar_req_id:
  - If cnt[b] == bar_req_size_m1 (last arrival; includes size_m1 == 0 with cnt 0): next cycle cnt[b] = 0, mask[b] = 0. release_valid = 1, release_id = b, release_mask = old mask[b] | onehot(wid). The requester is never stalled.
  - Else: next cycle cnt[b] += 1, mask[b] |= onehot(wid), bar_stall_mask[wid] = 1.
- Latency: the stall bit is registered, one cycle after the request. Unstall happens in the same cycle as release_valid, one cycle after the last arrival. bar_stall_mask = OR of all mask[b].
- release_valid is high for exactly one cycle per release. A back-to-back release on another barrier in the next cycle is allowed.
- Errors: the request is ignored (no state change) and err_valid is set sticky if any of the following holds:
  - the requesting warp is already set in bar_stall_mask;
  - barrier b is WAITING and bar_req_size_m1 differs from the latched size;
  - wid already appears in mask[b].
- Counter width: cnt never exceeds size_m1 ≤ NUM_WARPS-1, so no wrap is possible. barrier_ctrs[b] falls from a nonzero value to 0 only on release.
- Different barriers are independent. Requests to barriers b1 and b2 on consecutive cycles do not interact.
- bar_req_* are don't-care when bar_req_valid = 0.

Optional Feature:
- Macro VX_BAR_TIMEOUT_EN.
- Enabled:
  - Each barrier has a cycle counter that clears on IDLE or release and increments while WAITING.
  - When a counter reaches TIMEOUT_CYCLES, timeout_valid sets (sticky until reset) and timeout_id captures the lowest-numbered timed-out barrier (first event only).
  - Barrier state is not altered.
- Disabled: no watchdog counters are instantiated; timeout_valid and timeout_id are tied to 0.

Test Plan:
- Reset, then 4-warp barrier 0 size_m1=3: warps 0,1,2 request on cycles 1-3 -> bar_stall_mask = 0001, 0011, 0111 one cycle after each request; barrier_ctrs[0] = 1,2,3. Warp 3 requests on cycle 4 -> cycle 5: release_valid=1, release_id=0, release_mask=1111, stall mask 0000, ctr 0.
- size_m1=0 request from warp 2 on barrier 1 -> no stall, release_valid=1 next cycle with release_mask=0100, ctr stays 0.
- Interleaving barrier 0 (size_m1=1: warps 0,1) and barrier 2 (size_m1=1: warps 2,3) on alternating cycles -> two independent releases with masks 0011 and 1100, release_id 0 then 2.
- Warp 1 waiting on barrier 0 requests barrier 3 -> ignored, err_valid=1, barrier_ctrs[3]=0. A size mismatch on a WAITING barrier also sets err_valid without a count change.
- Assert reset while barrier 0 has cnt=2 -> next cycle all ctrs 0, stall mask 0, no release pulse; a subsequent full barrier sequence releases normally.
- VX_BAR_TIMEOUT_EN with TIMEOUT_CYCLES=16: one warp waits on barrier 2 (size_m1=1) with no partner -> timeout_valid=1, timeout_id=2 at 16 cycles; stall bit stays 1. Without the macro, timeout_valid remains 0.
